// File: rtl/dsram_pkg.sv
// Shared widths, constants and the arbiter state type for the dsram data array.
package dsram_pkg;

  localparam int LINE_W = 256;
  localparam int BE_W   = 32;

  // Every byte lane enabled: a fill always writes a whole line.
  localparam logic [BE_W-1:0] BE_FULL = '1;

  // Arbiter state: ARB arbitrates each cycle; LOCK keeps the array for fill.
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dsram_arb.sv
// Per-way arbiter for one dsram data array. It shares the single array port
// between the core load/store path and the fill/evict path.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ARB   | per-cycle arbitration: starved core, else fill, else core
//   LOCK  | fill owns the array; the core is held off until fill_lock drops
//
// Fill normally has priority. A saturating starvation counter forces one core
// grant after STARVE_MAX consecutive denied cycles. The counter keeps
// saturating through LOCK, so a core still waiting when LOCK ends goes first.
module dsram_arb
  import dsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [BE_W-1:0]       core_be,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [LINE_W-1:0]     core_wd,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  input  logic                  fill_req,
  input  logic                  fill_we,
  input  logic                  fill_lock,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [LINE_W-1:0]     fill_wd,
  output logic                  fill_gnt,
  output logic                  fill_rvalid,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [BE_W-1:0]       sram_be,
  output logic [LINE_W-1:0]     sram_wd,
  output logic                  sram_write,
  output logic                  sram_read,
  input  logic [LINE_W-1:0]     sram_rd,
  output logic [LINE_W-1:0]     rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       core_rvalid_q, core_rvalid_d;
  logic       fill_rvalid_q, fill_rvalid_d;
  logic       starve_force;

  assign starve_force = (starve_cnt_q == STARVE_LIM) && core_req;

  // Grant selection; both grants are held low while reset is asserted.
  always_comb begin
    core_gnt = 1'b0;
    fill_gnt = 1'b0;
    if (rst_n) begin
      case (state_q)
        ARB: begin
          if (starve_force) begin
            core_gnt = 1'b1;
          end else if (fill_req) begin
            fill_gnt = 1'b1;
          end else if (core_req) begin
            core_gnt = 1'b1;
          end
        end
        LOCK: begin
          fill_gnt = fill_req;
        end
        default: begin
          core_gnt = 1'b0;
          fill_gnt = 1'b0;
        end
      endcase
    end
  end

  // Array port drive from the granted requester; address/data default to fill.
  always_comb begin
    sram_a     = fill_addr;
    sram_wd    = fill_wd;
    sram_be    = '0;
    sram_write = 1'b0;
    sram_read  = 1'b0;
    if (core_gnt) begin
      sram_a  = core_addr;
      sram_wd = core_wd;
      if (core_we) begin
        // An all-zero byte mask is accepted but leaves the array untouched.
        sram_be    = core_be;
        sram_write = (core_be != '0);
      end else begin
        sram_read = 1'b1;
      end
    end else if (fill_gnt) begin
      if (fill_we) begin
        sram_be    = BE_FULL;
        sram_write = 1'b1;
      end else begin
        sram_read = 1'b1;
      end
    end
  end

  // Next state: enter LOCK on a locked fill grant, leave when the lock drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (fill_gnt && fill_lock) state_d = LOCK;
      LOCK:    if (!fill_lock) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Starvation counter: count denied core cycles, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (core_gnt || !core_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Read-return flags: a granted read returns data on the following cycle.
  always_comb begin
    core_rvalid_d = core_gnt && !core_we;
    fill_rvalid_d = fill_gnt && !fill_we;
  end

  // State, counter and read-return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB;
      starve_cnt_q  <= '0;
      core_rvalid_q <= 1'b0;
      fill_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      core_rvalid_q <= core_rvalid_d;
      fill_rvalid_q <= fill_rvalid_d;
    end
  end

  assign core_rvalid = core_rvalid_q;
  assign fill_rvalid = fill_rvalid_q;

  // The array output already carries the registered read data; pass it through.
  assign rdata = sram_rd;

endmodule
